// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the write-through data cache.
//   - word/address widths matching dm
//   - line index / tag split and the helper that performs it
//   - controller state encoding
package dcache_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 12;
  localparam int IDX_BITS  = 4;
  localparam int LINES     = 1 << IDX_BITS;
  localparam int TAG_W     = ADDR_W - 2 - IDX_BITS;
  localparam int WR_CYCLES = 3;
  localparam int CNT_W     = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]    tag_t;

  typedef struct packed {
    tag_t tag;
    idx_t idx;
  } line_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_HOLD
  } state_t;

  // Takes the word address (byte offset already dropped) and splits it
  // into the line index and the tag stored alongside the line.
  function automatic line_addr_t split_addr(input logic [ADDR_W-3:0] waddr);
    line_addr_t la;
    la.idx = waddr[IDX_BITS-1:0];
    la.tag = waddr[ADDR_W-3:IDX_BITS];
    return la;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: storage for the direct-mapped cache lines.
//   clock, reset   : clock and synchronous active-high reset
//   flush          : clears every valid bit in one cycle
//   idx            : line index shared by the read and write ports
//   rd_valid/tag/data : asynchronous read of line idx
//   data_we, data_in  : write the data word of line idx
//   set_line, tag_in  : mark line idx valid and record its tag (refill)
module dcache_array
  import dcache_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  flush,
  input  idx_t  idx,
  output logic  rd_valid,
  output tag_t  rd_tag,
  output data_t rd_data,
  input  logic  data_we,
  input  data_t data_in,
  input  logic  set_line,
  input  tag_t  tag_in
);

  // Valid bits are plain flops so reset and flush clear all lines at once;
  // tags and data need no reset because they are never used while invalid.
  logic [LINES-1:0] valid;
  tag_t             tags [LINES];
  data_t            data [LINES];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid <= '0;
    end else if (set_line) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (data_we) begin
      data[idx] <= data_in;
    end
    if (set_line) begin
      tags[idx] <= tag_in;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx];

endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, one-word-per-line data cache
// sitting between the CPU load/store stage and dm.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata : CPU request, held until cpu_ack
//   cpu_flush             : invalidate all lines (honoured only when idle)
//   cpu_rdata, cpu_ack    : load data and 1-cycle completion pulse
//   cpu_busy              : controller not idle
//   DM_enable/read/write  : dm request strobe and qualifiers (1-cycle pulse)
//   DM_address, DM_in     : dm address / write data, held for the transaction
//   DM_out, DM_ready      : dm read data and read-complete flag
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting; flush handled here, request latched here
// ST_LOOKUP   | tag compare; load hit acks, load miss / store go to dm
// ST_RD_ISSUE | dm read strobe high for this single cycle
// ST_RD_WAIT  | waiting for DM_ready; refill line and ack on arrival
// ST_WR_HOLD  | dm write in flight; address/data held WR_CYCLES cycles
module dcache_wt
  import dcache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  output logic              DM_enable,
  output logic              DM_read,
  output logic              DM_write,
  output logic [ADDR_W-1:0] DM_address,
  output logic [DATA_W-1:0] DM_in,
  input  logic [DATA_W-1:0] DM_out,
  input  logic              DM_ready
);

  state_t           state;
  logic             req_we;
  addr_t            req_addr;
  data_t            req_wdata;
  logic [CNT_W-1:0] hold_cnt;

  line_addr_t req_line;
  logic       rd_valid;
  tag_t       rd_tag;
  data_t      rd_data;
  logic       hit;
  logic       flush_all;
  logic       store_hit;
  logic       fill;

  assign req_line  = split_addr(req_addr[ADDR_W-1:2]);
  assign hit       = rd_valid && (rd_tag == req_line.tag);
  assign flush_all = (state == ST_IDLE) && cpu_flush;
  // Stores update the line only when it already holds this address;
  // a store miss goes to dm alone (no write-allocate).
  assign store_hit = (state == ST_LOOKUP) && req_we && hit;
  assign fill      = (state == ST_RD_WAIT) && DM_ready;
  assign cpu_busy  = (state != ST_IDLE);

  dcache_array u_array (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush_all),
    .idx      (req_line.idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .data_we  (store_hit || fill),
    .data_in  (fill ? DM_out : req_wdata),
    .set_line (fill),
    .tag_in   (req_line.tag)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      hold_cnt   <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      DM_enable  <= 1'b0;
      DM_read    <= 1'b0;
      DM_write   <= 1'b0;
      DM_address <= '0;
      DM_in      <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Flush wins over a simultaneous request; the request is taken
          // the following cycle. The ack cycle itself is skipped so a
          // request still high while ack is visible is not taken twice.
          if (!cpu_flush && cpu_req && !cpu_ack) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (req_we) begin
            DM_enable  <= 1'b1;
            DM_write   <= 1'b1;
            DM_address <= req_addr;
            DM_in      <= req_wdata;
            hold_cnt   <= CNT_W'(WR_CYCLES - 1);
            state      <= ST_WR_HOLD;
          end else if (hit) begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= rd_data;
            state     <= ST_IDLE;
          end else begin
            DM_enable  <= 1'b1;
            DM_read    <= 1'b1;
            DM_address <= req_addr;
            state      <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          // DM_ready seen here belongs to an earlier transaction.
          DM_enable <= 1'b0;
          DM_read   <= 1'b0;
          state     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (DM_ready) begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= DM_out;
            state     <= ST_IDLE;
          end
        end
        ST_WR_HOLD: begin
          DM_enable <= 1'b0;
          DM_write  <= 1'b0;
          if (hold_cnt == '0) begin
            cpu_ack <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed scoreboard bench for dcache_wt with a small dm
// model (3-cycle read latency, write consumed 2 edges after the strobe).
module tb_dcache_wt;
  import dcache_pkg::*;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_flush;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;
  logic        DM_enable;
  logic        DM_read;
  logic        DM_write;
  logic [11:0] DM_address;
  logic [31:0] DM_in;
  logic [31:0] DM_out;
  logic        DM_ready;

  dcache_wt dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_flush  (cpu_flush),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_busy   (cpu_busy),
    .DM_enable  (DM_enable),
    .DM_read    (DM_read),
    .DM_write   (DM_write),
    .DM_address (DM_address),
    .DM_in      (DM_in),
    .DM_out     (DM_out),
    .DM_ready   (DM_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        is_store;
    logic [31:0] rdata;
    int          lat;
    int          issue;
  } cpu_exp_t;

  typedef struct {
    logic        is_write;
    logic [11:0] addr;
    logic [31:0] data;
  } dm_exp_t;

  cpu_exp_t sbq[$];
  dm_exp_t  dmq[$];

  // ---------------- dm model ----------------
  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;
  int          rd_cnt;
  int          wr_cnt;
  logic [9:0]  rd_word;

  always @(posedge clock) begin
    if (reset) begin
      DM_ready <= 1'b0;
      DM_out   <= 32'h0;
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      rd_word  <= 10'h0;
      if (!mem_init) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        mem[20]  <= 32'h0BAD_F00D;   // byte 0x050
        mem[12]  <= 32'h1234_5678;   // byte 0x030
        mem_init <= 1'b1;
      end
    end else begin
      DM_ready <= 1'b0;
      if (DM_enable && DM_read) begin
        rd_cnt  <= 3;
        rd_word <= DM_address[11:2];
      end else if (rd_cnt > 0) begin
        rd_cnt <= rd_cnt - 1;
        if (rd_cnt == 1) begin
          DM_ready <= 1'b1;
          DM_out   <= mem[rd_word];
        end
      end
      if (DM_enable && DM_write) begin
        wr_cnt <= 2;
      end else if (wr_cnt > 0) begin
        wr_cnt <= wr_cnt - 1;
        if (wr_cnt == 1) mem[DM_address[11:2]] <= DM_in;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          to_cnt  = 0;
  int          to_seen = 0;
  logic        chk_idle  = 1'b0;
  logic        chk_final = 1'b0;
  logic        prev_en   = 1'b0;
  int          hold_left = 0;
  logic [11:0] hold_addr;
  logic [31:0] hold_data;

  always @(negedge clock) begin
    cpu_exp_t e;
    dm_exp_t  d;
    while (to_seen < to_cnt) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: DUT response got none within bound, required one");
      to_seen++;
    end
    if (chk_idle) begin
      n_tests++;
      if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || DM_enable !== 1'b0 ||
          DM_read !== 1'b0 || DM_write !== 1'b0 || DM_address !== 12'h0 ||
          DM_in !== 32'h0 || cpu_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state: busy=%0b ack=%0b en=%0b rd=%0b wr=%0b addr=%h din=%h rdata=%h, required all zero",
                 cpu_busy, cpu_ack, DM_enable, DM_read, DM_write, DM_address, DM_in, cpu_rdata);
      end
    end
    if (chk_final) begin
      n_tests++;
      if (sbq.size() != 0 || dmq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: cpu_pending=%0d dm_pending=%0d, required 0 0", sbq.size(), dmq.size());
      end
    end
    if (reset) begin
      hold_left = 0;
    end else begin
      if (cpu_ack) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: got ack rdata=%h, required no ack", cpu_rdata);
        end else begin
          e = sbq.pop_front();
          if (!e.is_store && cpu_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL load_rdata: got %h, required %h", cpu_rdata, e.rdata);
          end
          if (e.lat >= 0) begin
            n_tests++;
            if ((cyc - e.issue) != e.lat) begin
              n_fail++;
              $display("FAIL ack_latency: got %0d cycles, required %0d", cyc - e.issue, e.lat);
            end
          end
        end
      end
      if (DM_enable) begin
        n_tests++;
        if (prev_en) begin
          n_fail++;
          $display("FAIL dm_pulse_width: got enable high 2+ cycles, required 1");
        end
        n_tests++;
        if (dmq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_dm: got rd=%0b wr=%0b addr=%h, required no dm access", DM_read, DM_write, DM_address);
        end else begin
          d = dmq.pop_front();
          if (DM_read !== !d.is_write || DM_write !== d.is_write || DM_address !== d.addr ||
              (d.is_write && DM_in !== d.data)) begin
            n_fail++;
            $display("FAIL dm_req: got rd=%0b wr=%0b addr=%h din=%h, required rd=%0b wr=%0b addr=%h din=%h",
                     DM_read, DM_write, DM_address, DM_in, !d.is_write, d.is_write, d.addr, d.data);
          end
          if (d.is_write) begin
            hold_left = WR_CYCLES - 1;
            hold_addr = d.addr;
            hold_data = d.data;
          end
        end
      end else begin
        n_tests++;
        if (DM_read || DM_write) begin
          n_fail++;
          $display("FAIL dm_qualifier: got rd=%0b wr=%0b with enable low, required 0 0", DM_read, DM_write);
        end
        if (hold_left > 0) begin
          n_tests++;
          if (DM_address !== hold_addr || DM_in !== hold_data) begin
            n_fail++;
            $display("FAIL dm_hold: got addr=%h din=%h, required addr=%h din=%h", DM_address, DM_in, hold_addr, hold_data);
          end
          hold_left--;
        end
      end
    end
    prev_en = DM_enable;
  end

  // ---------------- stimulus ----------------
  // dm_kind: 0 = no dm access expected, 1 = dm read, 2 = dm write.
  // lat: expected cycles from issue to ack, or -1 when not checked.
  task automatic access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int dm_kind, input int lat,
                        input logic with_flush);
    cpu_exp_t e;
    dm_exp_t  d;
    bit       got;
    @(posedge clock);
    #1;
    if (dm_kind != 0) begin
      d.is_write = (dm_kind == 2);
      d.addr     = addr;
      d.data     = wdata;
      dmq.push_back(d);
    end
    e.is_store = we;
    e.rdata    = exp_rdata;
    e.lat      = lat;
    e.issue    = cyc;
    sbq.push_back(e);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_flush = with_flush;
    if (with_flush) begin
      @(posedge clock);
      #1 cpu_flush = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    if (!got) to_cnt++;
  endtask

  initial begin
    dm_exp_t d;
    bit      got;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 12'h0;
    cpu_wdata = 32'h0;
    cpu_flush = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_idle = 1'b1;
    @(negedge clock);
    #1 chk_idle = 1'b0;
    reset = 1'b0;

    // cold miss, then hit on the refilled line
    access(1'b0, 12'h010, 32'h0, 32'h0000_0000, 1, -1, 1'b0);
    access(1'b0, 12'h010, 32'h0, 32'h0000_0000, 0,  2, 1'b0);
    // store hit writes through; following load hits with new data
    access(1'b1, 12'h010, 32'hDEAD_BEEF, 32'h0, 2, 5, 1'b0);
    access(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 0,  2, 1'b0);
    // same index, new tag: conflict refills
    access(1'b0, 12'h050, 32'h0, 32'h0BAD_F00D, 1, -1, 1'b0);
    access(1'b0, 12'h050, 32'h0, 32'h0BAD_F00D, 0,  2, 1'b0);
    access(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1, -1, 1'b0);
    access(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 0,  2, 1'b0);
    // store miss does not allocate
    access(1'b1, 12'h020, 32'hCAFE_F00D, 32'h0, 2, 5, 1'b0);
    access(1'b0, 12'h020, 32'h0, 32'hCAFE_F00D, 1, -1, 1'b0);
    access(1'b0, 12'h020, 32'h0, 32'hCAFE_F00D, 0,  2, 1'b0);
    access(1'b1, 12'h020, 32'h55AA_33CC, 32'h0, 2, 5, 1'b0);
    access(1'b0, 12'h020, 32'h0, 32'h55AA_33CC, 0,  2, 1'b0);
    // flush with request: flush first, request then misses
    access(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1, -1, 1'b1);
    access(1'b0, 12'h020, 32'h0, 32'h55AA_33CC, 1, -1, 1'b0);

    // reset while waiting for dm read data
    @(posedge clock);
    #1;
    d.is_write = 1'b0;
    d.addr     = 12'h030;
    d.data     = 32'h0;
    dmq.push_back(d);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 12'h030;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (DM_enable) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_cnt++;
    @(posedge clock);
    #1;
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clock);
    #1 chk_idle = 1'b1;
    @(negedge clock);
    #1 chk_idle = 1'b0;
    reset = 1'b0;

    // nothing survives reset
    access(1'b0, 12'h030, 32'h0, 32'h1234_5678, 1, -1, 1'b0);
    access(1'b0, 12'h030, 32'h0, 32'h1234_5678, 0,  2, 1'b0);
    access(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1, -1, 1'b0);

    repeat (4) @(posedge clock);
    #1 chk_final = 1'b1;
    @(negedge clock);
    #1 chk_final = 1'b0;
    @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
